// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: accumulates a running CRC over multi-beat, byte-enabled messages
// and returns one finalised CRC plus a saturating byte count per message.
module crc_stream_engine #(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned CRC_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [CRC_WIDTH-1:0]    cfg_polynomial_i,
    input  logic [CRC_WIDTH-1:0]    cfg_init_i,
    input  logic [CRC_WIDTH-1:0]    cfg_xor_out_i,
    input  logic                    cfg_reflect_in_i,
    input  logic                    cfg_reflect_out_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [DATA_BYTES*8-1:0] s_data_i,
    input  logic [DATA_BYTES-1:0]   s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_abort_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [CRC_WIDTH-1:0]    m_crc_o,
    output logic [31:0]             m_bytes_o
);

    typedef enum logic [1:0] {StIdle, StAccum, StResult} state_e;

    state_e               state_q;
    logic [CRC_WIDTH-1:0] poly_q, xor_out_q, crc_q, m_crc_q;
    logic                 reflect_in_q, reflect_out_q, s_ready_q, m_valid_q;
    logic [31:0]          bytes_q, m_bytes_q;

    logic                 is_idle, accept, abort;
    logic [CRC_WIDTH-1:0] poly_eff, xor_eff, crc_start, crc_next, crc_xored, crc_final;
    logic                 rin_eff, rout_eff;
    logic [31:0]          bytes_base, keep_count, bytes_next;
    logic [32:0]          bytes_sum;

    assign is_idle = (state_q == StIdle);
    assign accept  = s_valid_i & s_ready_q;
    assign abort   = s_abort_i & (state_q != StResult);

    // The first beat of a message uses the live config; later beats use the captured copy.
    assign poly_eff   = is_idle ? cfg_polynomial_i  : poly_q;
    assign xor_eff    = is_idle ? cfg_xor_out_i     : xor_out_q;
    assign rin_eff    = is_idle ? cfg_reflect_in_i  : reflect_in_q;
    assign rout_eff   = is_idle ? cfg_reflect_out_i : reflect_out_q;
    assign crc_start  = is_idle ? cfg_init_i        : crc_q;
    assign bytes_base = is_idle ? 32'd0             : bytes_q;

    always_comb begin
        logic [7:0] b;
        logic [7:0] b_rev;
        crc_next = crc_start;
        b        = '0;
        b_rev    = '0;
        for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            if (s_keep_i[DATA_BYTES-1-i]) begin
                b = s_data_i[8*(DATA_BYTES-1-i) +: 8];
                for (int unsigned k = 0; k < 8; k++) begin
                    b_rev[k] = b[7-k];
                end
                if (rin_eff) begin
                    b = b_rev;
                end
                crc_next = crc_next ^ (CRC_WIDTH'(b) << (CRC_WIDTH-8));
                for (int unsigned k = 0; k < 8; k++) begin
                    crc_next = crc_next[CRC_WIDTH-1] ? ((crc_next << 1) ^ poly_eff)
                                                     : (crc_next << 1);
                end
            end
        end
    end

    always_comb begin
        crc_xored = crc_next ^ xor_eff;
        crc_final = crc_xored;
        if (rout_eff) begin
            for (int unsigned k = 0; k < CRC_WIDTH; k++) begin
                crc_final[k] = crc_xored[CRC_WIDTH-1-k];
            end
        end
    end

    always_comb begin
        keep_count = '0;
        for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            keep_count = keep_count + 32'(s_keep_i[i]);
        end
        bytes_sum  = {1'b0, bytes_base} + {1'b0, keep_count};
        bytes_next = bytes_sum[32] ? 32'hFFFF_FFFF : bytes_sum[31:0];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            poly_q        <= '0;
            xor_out_q     <= '0;
            reflect_in_q  <= 1'b0;
            reflect_out_q <= 1'b0;
            crc_q         <= '0;
            bytes_q       <= '0;
            m_crc_q       <= '0;
            m_bytes_q     <= '0;
            m_valid_q     <= 1'b0;
            s_ready_q     <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    // Abort takes priority over a beat presented in the same cycle.
                    if (abort) begin
                        state_q <= StIdle;
                        crc_q   <= '0;
                        bytes_q <= '0;
                    end else if (accept) begin
                        crc_q   <= crc_next;
                        bytes_q <= bytes_next;
                        if (is_idle) begin
                            poly_q        <= cfg_polynomial_i;
                            xor_out_q     <= cfg_xor_out_i;
                            reflect_in_q  <= cfg_reflect_in_i;
                            reflect_out_q <= cfg_reflect_out_i;
                        end
                        if (s_last_i) begin
                            state_q   <= StResult;
                            m_crc_q   <= crc_final;
                            m_bytes_q <= bytes_next;
                            m_valid_q <= 1'b1;
                            s_ready_q <= 1'b0;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StResult: begin
                    if (m_ready_i) begin
                        state_q   <= StIdle;
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        crc_q     <= '0;
                        bytes_q   <= '0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    m_valid_q <= 1'b0;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_crc_o   = m_crc_q;
    assign m_bytes_o = m_bytes_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench: two engine instances (8-byte/CRC-32 and 1-byte/CRC-16) checked against
// known CRC catalogue values and a byte-queue reference model under random stimulus.
module tb_crc_stream_engine;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    // 8-byte beats, CRC-32
    logic [31:0] a_poly, a_init, a_xor;
    logic        a_rin, a_rout, a_valid, a_ready, a_last, a_abort, a_mvalid, a_mready;
    logic [63:0] a_data;
    logic [7:0]  a_keep;
    logic [31:0] a_crc, a_bytes;

    // 1-byte beats, CRC-16
    logic [15:0] b_poly, b_init, b_xor;
    logic        b_rin, b_rout, b_valid, b_ready, b_last, b_abort, b_mvalid, b_mready;
    logic [7:0]  b_data;
    logic [0:0]  b_keep;
    logic [15:0] b_crc;
    logic [31:0] b_bytes;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] msg_q[$];

    crc_stream_engine #(.DATA_BYTES(8), .CRC_WIDTH(32)) u_dut_a (
        .clk(clk), .n_rst(n_rst),
        .cfg_polynomial_i(a_poly), .cfg_init_i(a_init), .cfg_xor_out_i(a_xor),
        .cfg_reflect_in_i(a_rin), .cfg_reflect_out_i(a_rout),
        .s_valid_i(a_valid), .s_ready_o(a_ready), .s_data_i(a_data), .s_keep_i(a_keep),
        .s_last_i(a_last), .s_abort_i(a_abort),
        .m_valid_o(a_mvalid), .m_ready_i(a_mready), .m_crc_o(a_crc), .m_bytes_o(a_bytes)
    );

    crc_stream_engine #(.DATA_BYTES(1), .CRC_WIDTH(16)) u_dut_b (
        .clk(clk), .n_rst(n_rst),
        .cfg_polynomial_i(b_poly), .cfg_init_i(b_init), .cfg_xor_out_i(b_xor),
        .cfg_reflect_in_i(b_rin), .cfg_reflect_out_i(b_rout),
        .s_valid_i(b_valid), .s_ready_o(b_ready), .s_data_i(b_data), .s_keep_i(b_keep),
        .s_last_i(b_last), .s_abort_i(b_abort),
        .m_valid_o(b_mvalid), .m_ready_i(b_mready), .m_crc_o(b_crc), .m_bytes_o(b_bytes)
    );

    // Reference CRC over the message byte queue, any width 8..32.
    function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input logic [31:0] xo,
                                            input bit rin, input bit rout);
        logic [31:0] mask;
        logic [31:0] c;
        logic [31:0] r;
        logic [7:0]  b;
        logic [7:0]  br;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        c = init & mask;
        foreach (msg_q[i]) begin
            b = msg_q[i];
            for (int k = 0; k < 8; k++) br[k] = b[7-k];
            if (rin) b = br;
            c = c ^ ({24'd0, b} << (w - 8));
            for (int s = 0; s < 8; s++) begin
                if (c[w-1]) c = ((c << 1) ^ poly) & mask;
                else        c = (c << 1) & mask;
            end
        end
        c = (c ^ xo) & mask;
        if (rout) begin
            r = '0;
            for (int k = 0; k < w; k++) r[w-1-k] = c[k];
            c = r;
        end
        return c;
    endfunction

    task automatic cfg_iso();
        a_poly = 32'h04C1_1DB7; a_init = 32'hFFFF_FFFF; a_xor = 32'hFFFF_FFFF;
        a_rin = 1'b1; a_rout = 1'b1;
    endtask

    task automatic send_a(input logic [63:0] d, input logic [7:0] k, input bit last,
                          input bit abort);
        vectors++;
        if (a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_a_ready: s_ready=%b required 1", a_ready);
        end
        a_valid = 1'b1; a_data = d; a_keep = k; a_last = last; a_abort = abort;
        @(posedge clk); #1;
        a_valid = 1'b0; a_last = 1'b0; a_abort = 1'b0; a_keep = '0;
        if (!abort) for (int j = 7; j >= 0; j--) if (k[j]) msg_q.push_back(d[8*j +: 8]);
    endtask

    task automatic send_b(input logic [7:0] d, input bit last);
        vectors++;
        if (b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_b_ready: s_ready=%b required 1", b_ready);
        end
        b_valid = 1'b1; b_data = d; b_keep = 1'b1; b_last = last;
        @(posedge clk); #1;
        b_valid = 1'b0; b_last = 1'b0;
        msg_q.push_back(d);
    endtask

    // Called right after the last beat: the result must already be visible, then retire it.
    task automatic result_a(input logic [31:0] crc, input logic [31:0] nb, input string name);
        int n = 0;
        while (a_mvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        vectors++;
        if (a_mvalid !== 1'b1) begin
            miscompares++; $display("FAIL %s_timeout: m_valid=%b required 1", name, a_mvalid);
        end else begin
            if (n != 0) begin
                miscompares++; $display("FAIL %s_latency: waited %0d cycles required 0", name, n);
            end
            vectors++;
            if (a_crc !== crc) begin
                miscompares++; $display("FAIL %s_crc: got %h required %h", name, a_crc, crc);
            end
            vectors++;
            if (a_bytes !== nb) begin
                miscompares++; $display("FAIL %s_bytes: got %0d required %0d", name, a_bytes, nb);
            end
        end
        a_mready = 1'b1; @(posedge clk); #1; a_mready = 1'b0;
        vectors++;
        if (a_mvalid !== 1'b0 || a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_retire: m_valid=%b s_ready=%b required 0 1", name, a_mvalid, a_ready);
        end
    endtask

    task automatic send_iso();
        msg_q.delete();
        send_a(64'h3132_3334_3536_3738, 8'hFF, 1'b0, 1'b0);
        send_a({8'h39, 32'($urandom), 24'($urandom)}, 8'h80, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        vectors++;
        if (a_mvalid !== 1'b0 || a_crc !== 32'd0 || a_bytes !== 32'd0 || a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_a: m_valid=%b m_crc=%h m_bytes=%0d s_ready=%b required 0 0 0 1",
                     a_mvalid, a_crc, a_bytes, a_ready);
        end
        vectors++;
        if (b_mvalid !== 1'b0 || b_crc !== 16'd0 || b_bytes !== 32'd0 || b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_b: m_valid=%b m_crc=%h m_bytes=%0d s_ready=%b required 0 0 0 1",
                     b_mvalid, b_crc, b_bytes, b_ready);
        end
    endtask

    task automatic test_iso_hdlc();
        cfg_iso();
        send_iso();
        result_a(32'hCBF4_3926, 32'd9, "iso_hdlc");
    endtask

    task automatic test_mpeg2();
        cfg_iso(); a_rin = 1'b0; a_rout = 1'b0; a_xor = 32'd0;
        send_iso();
        result_a(32'h0376_E6E7, 32'd9, "mpeg2");
    endtask

    task automatic test_ccitt();
        logic [71:0] s;
        int n = 0;
        s = "123456789";
        b_poly = 16'h1021; b_init = 16'hFFFF; b_xor = 16'h0000; b_rin = 1'b0; b_rout = 1'b0;
        msg_q.delete();
        for (int i = 8; i >= 0; i--) send_b(s[8*i +: 8], i == 0);
        while (b_mvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        vectors++;
        if (b_mvalid !== 1'b1 || b_crc !== 16'h29B1 || b_bytes !== 32'd9) begin
            miscompares++;
            $display("FAIL ccitt: m_valid=%b m_crc=%h m_bytes=%0d required 1 29b1 9",
                     b_mvalid, b_crc, b_bytes);
        end
        b_mready = 1'b1; @(posedge clk); #1; b_mready = 1'b0;
        // Random 1-byte messages against the model
        for (int t = 0; t < 6; t++) begin
            logic [31:0] exp;
            int len;
            b_poly = 16'($urandom) | 16'h1; b_init = 16'($urandom); b_xor = 16'($urandom);
            b_rin = 1'($urandom); b_rout = 1'($urandom);
            len = $urandom_range(1, 6);
            msg_q.delete();
            for (int i = 0; i < len; i++) send_b(8'($urandom), i == len - 1);
            exp = ref_crc(16, {16'd0, b_poly}, {16'd0, b_init}, {16'd0, b_xor}, b_rin, b_rout);
            vectors++;
            if (b_mvalid !== 1'b1 || b_crc !== exp[15:0] || b_bytes !== 32'(len)) begin
                miscompares++;
                $display("FAIL ccitt_rand: m_valid=%b m_crc=%h m_bytes=%0d required 1 %h %0d",
                         b_mvalid, b_crc, b_bytes, exp[15:0], len);
            end
            b_mready = 1'b1; @(posedge clk); #1; b_mready = 1'b0;
        end
    endtask

    task automatic test_empty_sparse();
        logic [63:0] d;
        logic [31:0] exp;
        cfg_iso();
        msg_q.delete();
        send_a(64'($urandom) << 32 | 64'($urandom), 8'h00, 1'b1, 1'b0);
        result_a(32'h0000_0000, 32'd0, "empty");
        d = {32'($urandom), 32'($urandom)};
        msg_q.delete();
        send_a(d, 8'h5A, 1'b1, 1'b0);
        exp = ref_crc(32, a_poly, a_init, a_xor, a_rin, a_rout);
        result_a(exp, 32'd4, "sparse");
        msg_q.delete();
        send_a({d[55:48], d[39:32], d[31:24], d[15:8], 32'($urandom)}, 8'hF0, 1'b1, 1'b0);
        result_a(exp, 32'd4, "packed");
    endtask

    task automatic test_random_cfg_change();
        for (int t = 0; t < 30; t++) begin
            logic [31:0] p, i0, x, exp;
            bit ri, ro;
            int nb, cnt;
            logic [7:0] k;
            p = $urandom | 32'h1; i0 = $urandom; x = $urandom; ri = 1'($urandom);
            ro = 1'($urandom);
            a_poly = p; a_init = i0; a_xor = x; a_rin = ri; a_rout = ro;
            nb = $urandom_range(1, 4);
            cnt = 0;
            msg_q.delete();
            for (int i = 0; i < nb; i++) begin
                k = 8'($urandom);
                cnt += $countones(k);
                send_a({32'($urandom), 32'($urandom)}, k, i == nb - 1, 1'b0);
                // Config wiggles after the first beat must not affect this message.
                a_poly = $urandom; a_init = $urandom; a_xor = $urandom;
                a_rin = 1'($urandom); a_rout = 1'($urandom);
            end
            exp = ref_crc(32, p, i0, x, ri, ro);
            result_a(exp, 32'(cnt), "random");
        end
    endtask

    task automatic test_backpressure();
        cfg_iso();
        send_iso();
        for (int c = 0; c < 5; c++) begin
            a_valid = 1'b1; a_abort = 1'($urandom); a_keep = 8'hFF; a_last = 1'b1;
            a_data = {32'($urandom), 32'($urandom)};
            @(posedge clk); #1;
            vectors++;
            if (a_mvalid !== 1'b1 || a_crc !== 32'hCBF4_3926 || a_ready !== 1'b0 ||
                a_bytes !== 32'd9) begin
                miscompares++;
                $display("FAIL backpressure: m_valid=%b m_crc=%h m_bytes=%0d s_ready=%b required 1 cbf43926 9 0",
                         a_mvalid, a_crc, a_bytes, a_ready);
            end
        end
        a_valid = 1'b0; a_abort = 1'b0; a_last = 1'b0; a_keep = '0;
        result_a(32'hCBF4_3926, 32'd9, "bp_retire");
    endtask

    task automatic test_abort();
        cfg_iso();
        msg_q.delete();
        send_a(64'h3132_3334_3536_3738, 8'hFF, 1'b0, 1'b0);
        send_a({32'($urandom), 32'($urandom)}, 8'hFF, 1'b1, 1'b1);
        send_a({32'($urandom), 32'($urandom)}, 8'hFF, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (a_mvalid !== 1'b0 || a_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL abort_no_result: m_valid=%b s_ready=%b required 0 1",
                         a_mvalid, a_ready);
            end
        end
        send_iso();
        result_a(32'hCBF4_3926, 32'd9, "after_abort");
    endtask

    task automatic test_back_to_back();
        cfg_iso();
        for (int m = 0; m < 3; m++) begin
            send_iso();
            result_a(32'hCBF4_3926, 32'd9, "b2b");
        end
    endtask

    task automatic test_reset_mid();
        cfg_iso();
        send_iso();
        #2 n_rst = 1'b0; #1;
        vectors++;
        if (a_mvalid !== 1'b0 || a_crc !== 32'd0 || a_bytes !== 32'd0 || a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_result: m_valid=%b m_crc=%h m_bytes=%0d s_ready=%b required 0 0 0 1",
                     a_mvalid, a_crc, a_bytes, a_ready);
        end
        #3 n_rst = 1'b1;
        @(posedge clk); #1;
        msg_q.delete();
        send_a(64'h3132_3334_3536_3738, 8'hFF, 1'b0, 1'b0);
        #2 n_rst = 1'b0; #1;
        vectors++;
        if (a_mvalid !== 1'b0 || a_crc !== 32'd0 || a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_accum: m_valid=%b m_crc=%h s_ready=%b required 0 0 1",
                     a_mvalid, a_crc, a_ready);
        end
        #3 n_rst = 1'b1;
        @(posedge clk); #1;
        send_iso();
        result_a(32'hCBF4_3926, 32'd9, "after_reset");
    endtask

    initial begin
        n_rst = 1'b0;
        a_poly = '0; a_init = '0; a_xor = '0; a_rin = 1'b0; a_rout = 1'b0;
        a_valid = 1'b0; a_data = '0; a_keep = '0; a_last = 1'b0; a_abort = 1'b0; a_mready = 1'b0;
        b_poly = '0; b_init = '0; b_xor = '0; b_rin = 1'b0; b_rout = 1'b0;
        b_valid = 1'b0; b_data = '0; b_keep = '0; b_last = 1'b0; b_abort = 1'b0; b_mready = 1'b0;
        #12 n_rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_iso_hdlc();
        test_mpeg2();
        test_ccitt();
        test_empty_sparse();
        test_random_cfg_change();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Streaming, parametrised CRC engine that accepts a message as a sequence of DATA_BYTES-wide beats over a valid/ready handshake. It keeps a running CRC across beats and returns one finalised CRC per message, together with the message byte count. It sits between a DMA/packet source and the checksum-consumer logic. It generalises the single-word CRC unit to multi-beat messages, byte-enable beats, backpressure and abort.

## Interface
- DATA_BYTES, 8, beat width in bytes (≥1)
- CRC_WIDTH, 32, CRC width in bits (≥8)
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- cfg_polynomial  in  CRC_WIDTH  normal-form polynomial, implicit top bit omitted
- cfg_init  in  CRC_WIDTH  initial CRC register value
- cfg_xor_out  in  CRC_WIDTH  final XOR value
- cfg_reflect_in  in  1  bit-reverse each input byte before processing
- cfg_reflect_out  in  1  bit-reverse the whole CRC after the final XOR
- s_valid  in  1  input beat valid
- s_ready  out  1  engine can accept a beat
- s_data  in  DATA_BYTES*8  beat data; byte DATA_BYTES-1 is first in message order
- s_keep  in  DATA_BYTES  per-byte enable; bit j qualifies byte j
- s_last  in  1  final beat of message
- s_abort  in  1  synchronous pulse: discard message in progress
- m_valid  out  1  result valid
- m_ready  in  1  result consumed
- m_crc  out  CRC_WIDTH  finalised CRC
- m_bytes  out  32  number of bytes processed in the message, saturating

## Operation
- States: IDLE (no message open), ACCUM (message open), RESULT (m_valid=1).
- Handshake rules:
  - Beat accepted when s_valid & s_ready.
  - s_ready = 1 in IDLE and ACCUM, 0 in RESULT.
  - Result retired when m_valid & m_ready.
- Config sampling: all cfg_* are sampled on the first accepted beat of a message (IDLE) and held in registers for that message. Changes to cfg_* mid-message have no effect.
- Per accepted beat, for j = DATA_BYTES-1 down to 0, only where s_keep[j]=1:
  - b = s_data[8j+:8], bit-reversed if reflect_in.
  - crc ^= b << (CRC_WIDTH-8).
  - Then 8 MSB-first shift steps: crc = crc[MSB] ? (crc<<1)^poly : crc<<1.
- Bytes with keep=0 are skipped on any beat, including non-contiguous patterns. A beat with s_keep=0 is legal.
- Start value: the first beat of a message starts from cfg_init; later beats start from the running CRC.
- Byte count: incremented by popcount(s_keep) per accepted beat and saturates at 0xFFFFFFFF.
- Transitions:
  - IDLE: accepted beat with s_last=0 → ACCUM; accepted beat with s_last=1 → RESULT.
  - ACCUM: accepted beat with s_last=1 → RESULT; s_abort → IDLE.
  - RESULT: m_ready → IDLE.
- Finalisation: m_crc = reflect_out ? rev(crc ^ xor_out) : (crc ^ xor_out). m_crc and m_bytes are registered on entry to RESULT.
- Abort:
  - s_abort in ACCUM, or in IDLE together with a beat, discards the beat and the partial state; next state is IDLE and no result is produced.
  - s_abort in RESULT is ignored.
  - s_abort wins over a simultaneously accepted beat.

## Timing
- Reset values: state IDLE, m_valid 0, m_crc 0, m_bytes 0, running CRC 0, s_ready 1.
- Throughput is one beat per cycle. The running CRC updates on the clock edge that accepts the beat.
- Latency: when the last beat is accepted at edge N, m_valid=1 from edge N (visible in cycle N+1).
- Backpressure: m_crc and m_bytes stay stable while m_valid=1 and m_ready=0. s_ready stays 0 until retire.
- When m_ready is sampled high at edge R, m_valid=0 and s_ready=1 after R. The next message's first beat can be accepted at edge R+1.
- Reset asserted mid-message or in RESULT immediately returns the engine to the reset values. No partial result is ever emitted.
- s_ready depends only on state, with no combinational path from s_valid or m_ready.

## Test plan
- CRC-32/ISO-HDLC:
  - Setup: DATA_BYTES=8, poly 0x04C11DB7, init 0xFFFFFFFF, xor_out 0xFFFFFFFF, reflect in/out 1.
  - Stimulus: beat 0x3132333435363738 (keep 0xFF), then 0x39xxxxxxxxxxxxxx (keep 0x80, last).
  - Required: m_crc 0xCBF43926, m_bytes 9.
- CRC-32/MPEG-2:
  - Setup: same "123456789" beats, reflect 0, xor_out 0.
  - Required: m_crc 0x0376E6E7.
- CRC-16/CCITT-FALSE:
  - Setup: CRC_WIDTH=16, DATA_BYTES=1, poly 0x1021, init 0xFFFF, no reflect, xor_out 0.
  - Stimulus: nine 1-byte beats "123456789".
  - Required: m_crc 0x29B1, m_bytes 9.
- Empty, sparse and out-of-order beats:
  - Single last beat with keep 0x00, ISO-HDLC config → m_crc 0x00000000, m_bytes 0.
  - Keep 0x5A with bytes interleaved → same CRC as the packed equivalent.
  - Config changed mid-message → ignored.
- Backpressure and abort:
  - Hold m_ready=0 for 5 cycles → m_crc stable, s_ready 0.
  - Abort after the first beat → no m_valid. The following message produces the correct 0xCBF43926.
- Reset mid-message:
  - Drop n_rst during ACCUM → m_valid 0, m_crc 0, s_ready 1.
  - After release, a full message produces the correct result.
